io_lockstep_checker: RTL

//   Synthesisable lockstep comparator for fabric-vs-gold I/O checking. Samples the fabric's
//   pad outputs/enables (I_top/T_top) and a gold model's outputs/enables every clock for a

---
 rtl/io_lockstep_checker.sv | 114 +++++++++++
 1 files changed

// File: rtl/io_lockstep_checker.sv
// Lockstep comparator: checks fabric pad outputs/enables against a gold model over a fixed window.
// Latency: done_o rises on the edge that registers the last sample, SETTLE_CYCLES+CHECK_CYCLES edges after start_i.
// No backpressure: every input is sampled on every edge of the window.
module io_lockstep_checker #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 0,
  parameter int CHECK_CYCLES  = 100,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk_system_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [WIDTH-1:0]     care_mask_i,
  input  logic [WIDTH-1:0]     io_dut_i,
  input  logic [WIDTH-1:0]     oe_dut_i,
  input  logic [WIDTH-1:0]     io_gold_i,
  input  logic [WIDTH-1:0]     oe_gold_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CNT_WIDTH-1:0] err_count_o,
  output logic [CNT_WIDTH-1:0] first_idx_o,
  output logic [WIDTH-1:0]     first_io_o,
  output logic [WIDTH-1:0]     first_oe_o,
  output logic                 first_valid_o
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]        SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] IDX_LAST    = CNT_WIDTH'(CHECK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ERR_MAX     = '1;

  // The cycle index must be able to represent every check cycle of the window.
  if (CHECK_CYCLES < 1 || (CNT_WIDTH < 31 && CHECK_CYCLES > (1 << CNT_WIDTH))) begin : g_bad_params
    $error("io_lockstep_checker: CHECK_CYCLES out of range for CNT_WIDTH");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

  state_t                 state;
  logic [SW-1:0]          settle_cnt;
  logic [CNT_WIDTH-1:0]   idx;
  logic [WIDTH-1:0]       io_diff;
  logic [WIDTH-1:0]       oe_diff;
  logic [WIDTH-1:0]       bit_mis;
  logic                   cyc_mis;

  // Data is only meaningful where the gold drives the pad; enable disagreement always counts.
  assign io_diff = io_dut_i ^ io_gold_i;
  assign oe_diff = oe_dut_i ^ oe_gold_i;
  assign bit_mis = care_mask_i & (oe_diff | (oe_gold_i & io_diff));
  assign cyc_mis = |bit_mis;

  always_ff @(posedge clk_system_i) begin
    if (reset_i || abort_i) begin
      state         <= ST_IDLE;
      settle_cnt    <= '0;
      idx           <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      err_count_o   <= '0;
      first_idx_o   <= '0;
      first_io_o    <= '0;
      first_oe_o    <= '0;
      first_valid_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state         <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
            settle_cnt    <= '0;
            idx           <= '0;
            busy_o        <= 1'b1;
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
            err_count_o   <= '0;
            first_idx_o   <= '0;
            first_io_o    <= '0;
            first_oe_o    <= '0;
            first_valid_o <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= ST_CHECK;
          else settle_cnt <= settle_cnt + 1'b1;
        end
        ST_CHECK: begin
          if (cyc_mis) begin
            if (err_count_o != ERR_MAX) err_count_o <= err_count_o + 1'b1;
            if (!first_valid_o) begin
              first_idx_o   <= idx;
              first_io_o    <= io_diff;
              first_oe_o    <= oe_diff;
              first_valid_o <= 1'b1;
            end
          end
          // The last sample's result and the verdict land on the same edge.
          if (idx == IDX_LAST) begin
            state  <= ST_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= (err_count_o == '0) && !cyc_mis;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
